// File: rtl/stack_arbiter_pkg.sv
// Shared types and defaults for the two-client stack arbiter.
package stack_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 12;
  localparam int DEFAULT_DEPTH = 8;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    DONE
  } state_e;

endpackage

// File: rtl/stack_arb_rr.sv
// Two-way round-robin grant with a last-grant pointer.
// The pointer advances only when the arbiter takes a grant.
module stack_arb_rr (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt0,
  output logic gnt1
);

  // last_q = 1 means client 1 was granted last, so client 0 wins a tie.
  logic last_q, last_d;

  always_comb begin
    gnt0   = req0 & (~req1 | last_q);
    gnt1   = req1 & (~req0 | ~last_q);
    last_d = last_q;
    if (take) last_d = gnt1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two clients onto a single push/pop stack port, one transaction at a time.
// Optional empty-pop rejection is enabled by defining STACK_ARB_EMPTY_CHK_EN.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic             pushenbl,
  output logic             popenbl,
  output logic [WIDTH-1:0] pushdatain,
  input  logic [WIDTH-1:0] popdataout,
  input  logic             stack_full,
  output logic             busy
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  OCC_MAX = CW'(DEPTH);

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             push_en, pop_en, take, gnt0, gnt1;

  stack_arb_rr u_rr (
    .clk  (clk),
    .reset(reset),
    .req0 (req0),
    .req1 (req1),
    .take (take),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    push_en = 1'b0;
    pop_en  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          take    = 1'b1;
          win_d   = gnt1;
          op_d    = gnt0 ? op0 : op1;
          wdata_d = gnt0 ? wdata0 : wdata1;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q == OP_PUSH) begin
          if (stack_full) err_d = 1'b1;
          else            push_en = 1'b1;
          state_d = DONE;
        end else begin
`ifdef STACK_ARB_EMPTY_CHK_EN
          if (occ_q == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            pop_en  = 1'b1;
            state_d = CAPT;
          end
`else
          pop_en  = 1'b1;
          state_d = CAPT;
`endif
        end
      end
      CAPT: begin
        rdata_d = popdataout;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Occupancy saturates at both ends rather than wrapping.
  always_comb begin
    occ_d = occ_q;
    if (push_en && occ_q != OCC_MAX)  occ_d = occ_q + CW'(1);
    else if (pop_en && occ_q != '0)   occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      occ_q   <= occ_d;
    end
  end

  assign pushenbl   = push_en;
  assign popenbl    = pop_en;
  assign pushdatain = wdata_q;
  assign ack0       = (state_q == DONE) & ~win_q;
  assign ack1       = (state_q == DONE) &  win_q;
  assign err0       = ack0 & err_q;
  assign err1       = ack1 & err_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q != IDLE);

endmodule
